uart_mmio: RTL and testbench

Memory-mapped UART peripheral on the processor's data-memory port, the block directly downstream of the CPU core's store/load path and upstream of the `FPGA_SERIAL_RX` / `FPGA_SERIAL_TX` pins. The CPU reaches it with ordinary `sw`/`lw` instructions to the 0x8000_00xx I/O window. The block has an 8N1 transmitter, an 8N1 receiver with a one-byte holding register, and status registers that software polls.

---
 rtl/uart_mmio.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_uart_mmio.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_mmio.sv
// Memory-mapped 8N1 UART for the CPU data-memory port.
// Register map (full 32-bit decode; all other addresses read as zero):
//   0x8000_0000  TX control (R)  bit0 = tx_ready
//   0x8000_0004  RX control (R)  bit0 = rx_valid, bit1 = rx_overrun
//   0x8000_0008  TX data    (W)  byte queued only while tx_ready
//   0x8000_000C  RX data    (R)  {24'b0, rx_byte}; clears rx_valid and rx_overrun
module uart_mmio #(
    parameter int unsigned CLOCK_FREQ = 50_000_000,
    parameter int unsigned BAUD_RATE  = 115_200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        we,
    input  logic        re,
    output logic [31:0] rdata,
    input  logic        FPGA_SERIAL_RX,
    output logic        FPGA_SERIAL_TX
);

    localparam int unsigned CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
    localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT) + 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

    localparam logic [31:0] ADDR_TX_CTRL = 32'h8000_0000;
    localparam logic [31:0] ADDR_RX_CTRL = 32'h8000_0004;
    localparam logic [31:0] ADDR_TX_DATA = 32'h8000_0008;
    localparam logic [31:0] ADDR_RX_DATA = 32'h8000_000C;

    typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;
    typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

    // Only the low byte of the store data is meaningful.
    logic unused_wdata;
    assign unused_wdata = ^wdata[31:8];

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic tx_write;
    logic rx_data_read;

    assign tx_write     = we && (addr == ADDR_TX_DATA);
    assign rx_data_read = re && (addr == ADDR_RX_DATA);

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    tx_state_e        tx_state_q, tx_state_d;
    logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]       tx_bit_q, tx_bit_d;
    logic [7:0]       tx_shift_q, tx_shift_d;
    logic             tx_line_q, tx_line_d;
    logic             tx_ready;

    assign tx_ready       = (tx_state_q == TxIdle);
    assign FPGA_SERIAL_TX = tx_line_q;

    // TX state register; the line output is registered so it changes on the same
    // edge as the state that defines it.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q <= TxIdle;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_line_q  <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_line_q  <= tx_line_d;
        end
    end

    // TX next state: each state holds for CLKS_PER_BIT cycles, data goes LSB first.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_line_d  = tx_line_q;
        unique case (tx_state_q)
            TxIdle: begin
                tx_line_d = 1'b1;
                tx_cnt_d  = '0;
                if (tx_write) begin
                    tx_state_d = TxStart;
                    tx_shift_d = wdata[7:0];
                    tx_line_d  = 1'b0;
                end
            end
            TxStart: begin
                if (tx_cnt_q == CNT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_state_d = TxData;
                    tx_line_d  = tx_shift_q[0];
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            TxData: begin
                if (tx_cnt_q == CNT_LAST) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = TxStop;
                        tx_line_d  = 1'b1;
                    end else begin
                        tx_bit_d   = tx_bit_q + 3'd1;
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                        tx_line_d  = tx_shift_q[1];
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            TxStop: begin
                tx_line_d = 1'b1;
                if (tx_cnt_q == CNT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_state_d = TxIdle;
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            default: begin
                tx_state_d = TxIdle;
                tx_line_d  = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    logic sync1_q, sync2_q;
    logic rx_in;

    assign rx_in = sync2_q;

    // Two-flop synchronizer; reset high so a reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= FPGA_SERIAL_RX;
            sync2_q <= sync1_q;
        end
    end

    rx_state_e        rx_state_q, rx_state_d;
    logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]       rx_bit_q, rx_bit_d;
    logic [7:0]       rx_shift_q, rx_shift_d;
    logic             rx_commit;

    // RX state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_q <= RxIdle;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
        end
    end

    // RX next state: half a bit to the start-bit centre, then one bit per sample.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_commit  = 1'b0;
        unique case (rx_state_q)
            RxIdle: begin
                rx_cnt_d = '0;
                if (!rx_in) begin
                    rx_state_d = RxStart;
                end
            end
            RxStart: begin
                if (rx_cnt_q == CNT_HALF) begin
                    rx_cnt_d = '0;
                    rx_bit_d = '0;
                    // Line back high at the centre: treat as a glitch.
                    rx_state_d = rx_in ? RxIdle : RxData;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RxData: begin
                if (rx_cnt_q == CNT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_in, rx_shift_q[7:1]};
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = RxStop;
                    end else begin
                        rx_bit_d = rx_bit_q + 3'd1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RxStop: begin
                if (rx_cnt_q == CNT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_state_d = RxIdle;
                    // A low stop bit is a framing error: the byte is dropped.
                    rx_commit  = rx_in;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            default: begin
                rx_state_d = RxIdle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // RX holding register and status flags
    // ------------------------------------------------------------------
    logic [7:0] rx_byte_q;
    logic       rx_valid_q;
    logic       rx_overrun_q;

    // Commit has priority over a same-cycle RX-data read; the read still returns
    // the old byte because rdata samples rx_byte_q before this edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_byte_q    <= '0;
            rx_valid_q   <= 1'b0;
            rx_overrun_q <= 1'b0;
        end else if (rx_commit) begin
            rx_byte_q  <= rx_shift_q;
            rx_valid_q <= 1'b1;
            if (rx_valid_q && !rx_data_read) begin
                rx_overrun_q <= 1'b1;
            end
        end else if (rx_data_read) begin
            rx_valid_q   <= 1'b0;
            rx_overrun_q <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Load data
    // ------------------------------------------------------------------
    logic [31:0] rdata_q, rdata_d;

    assign rdata = rdata_q;

    // Read mux; status reflects the state before this cycle's edge.
    always_comb begin
        rdata_d = '0;
        if (re) begin
            if (addr == ADDR_TX_CTRL) begin
                rdata_d = {31'b0, tx_ready};
            end else if (addr == ADDR_RX_CTRL) begin
                rdata_d = {30'b0, rx_overrun_q, rx_valid_q};
            end else if (addr == ADDR_RX_DATA) begin
                rdata_d = {24'b0, rx_byte_q};
            end
        end
    end

    // Registered load data, one cycle after re.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

endmodule

// File: tb/tb_uart_mmio.sv
// Self-checking bench for uart_mmio: bus reads/writes, TX line decode against
// the expected 8N1 waveform, RX frames checked against a flag/byte model.
module tb_uart_mmio;

    localparam int unsigned CLOCK_FREQ = 50_000_000;
    localparam int unsigned BAUD_RATE  = 115_200;
    localparam int          CPB        = CLOCK_FREQ / BAUD_RATE;

    localparam logic [31:0] A_TXC = 32'h8000_0000;
    localparam logic [31:0] A_RXC = 32'h8000_0004;
    localparam logic [31:0] A_TXD = 32'h8000_0008;
    localparam logic [31:0] A_RXD = 32'h8000_000C;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic        re;
    logic [31:0] rdata;
    logic        serial_rx;
    logic        serial_tx;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model of the software-visible RX state.
    logic       m_valid;
    logic       m_overrun;
    logic [7:0] m_byte;

    always #5 clk = ~clk;

    uart_mmio #(
        .CLOCK_FREQ(CLOCK_FREQ),
        .BAUD_RATE (BAUD_RATE)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .addr          (addr),
        .wdata         (wdata),
        .we            (we),
        .re            (re),
        .rdata         (rdata),
        .FPGA_SERIAL_RX(serial_rx),
        .FPGA_SERIAL_TX(serial_tx)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        addr = a;
        re   = 1'b1;
        step();
        re   = 1'b0;
        addr = '0;
        d    = rdata;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        step();
        we    = 1'b0;
        addr  = '0;
    endtask

    task automatic model_clear();
        m_valid   = 1'b0;
        m_overrun = 1'b0;
    endtask

    task automatic rd_rxc(input string tag);
        logic [31:0] d;
        bus_read(A_RXC, d);
        check_eq(tag, d, {30'b0, m_overrun, m_valid});
    endtask

    task automatic rd_rxd(input string tag);
        logic [31:0] d;
        bus_read(A_RXD, d);
        check_eq(tag, d, {24'b0, m_byte});
        model_clear();
    endtask

    task automatic rd_txc(input string tag, input logic exp);
        logic [31:0] d;
        bus_read(A_TXC, d);
        check_eq(tag, d, {31'b0, exp});
    endtask

    // Drive one frame on the RX pin. stop_low = 0 gives a valid stop bit;
    // otherwise the stop bit is held low that many cycles (past its centre)
    // and then released, so the line recovers without looking like a new start.
    task automatic rx_drive(input logic [7:0] b, input int stop_low);
        serial_rx = 1'b0;
        repeat (CPB) step();
        for (int i = 0; i < 8; i++) begin
            serial_rx = b[i];
            repeat (CPB) step();
        end
        if (stop_low > 0) begin
            serial_rx = 1'b0;
            repeat (stop_low) step();
        end
        serial_rx = 1'b1;
        repeat (CPB) step();
    endtask

    task automatic rx_frame(input logic [7:0] b);
        rx_drive(b, 0);
        if (m_valid) m_overrun = 1'b1;
        m_valid = 1'b1;
        m_byte  = b;
    endtask

    // Store a byte and watch the line for one frame plus one idle bit time.
    // Offset c counts cycles after the accepting edge; status reads are issued
    // so they sample at edges 1, 10*CPB and 10*CPB+1 after it.
    task automatic tx_frame_check(input logic [7:0] b, input bit extra_store);
        int          bad [11];
        int          idx;
        logic        exp_bit;
        logic [31:0] r0, r1, r2;
        foreach (bad[i]) bad[i] = 0;
        r0 = '1;
        r1 = '1;
        r2 = '0;
        bus_write(A_TXD, {$urandom_range(0, 32'h00FF_FFFF), 8'h00} | {24'h0, b});
        for (int c = 0; c < 11 * CPB; c++) begin
            idx = c / CPB;
            if (idx == 0) exp_bit = 1'b0;
            else if (idx <= 8) exp_bit = b[idx-1];
            else exp_bit = 1'b1;
            if (serial_tx !== exp_bit) bad[idx]++;
            if (c == 1) r0 = rdata;
            if (c == 10 * CPB) r1 = rdata;
            if (c == 10 * CPB + 1) r2 = rdata;
            re = 1'b0;
            we = 1'b0;
            addr = '0;
            if (c == 0 || c == 10 * CPB - 1 || c == 10 * CPB) begin
                re   = 1'b1;
                addr = A_TXC;
            end
            if (extra_store && c == 2000) begin
                we    = 1'b1;
                addr  = A_TXD;
                wdata = {24'h0, ~b};
            end
            step();
        end
        re = 1'b0;
        we = 1'b0;
        for (int i = 0; i < 11; i++) begin
            check_eq($sformatf("tx_bit%0d_errs", i), bad[i], 0);
        end
        check_eq("tx_ready_early", r0, 32'h0);
        check_eq("tx_ready_last", r1, 32'h0);
        check_eq("tx_ready_after", r2, 32'h1);
    endtask

    initial begin
        #(99_000 * 10);
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] d;
        logic [7:0]  b;
        rst       = 1'b1;
        addr      = '0;
        wdata     = '0;
        we        = 1'b0;
        re        = 1'b0;
        serial_rx = 1'b1;
        m_valid   = 1'b0;
        m_overrun = 1'b0;
        m_byte    = 8'h00;
        repeat (3) step();
        check_eq("rst_tx_line", {31'b0, serial_tx}, 32'h1);
        check_eq("rst_rdata", rdata, 32'h0);
        rst = 1'b0;
        step();

        rd_txc("rst_tx_ready", 1'b1);
        rd_rxc("rst_rx_ctrl");
        rd_rxd("rst_rx_data");
        bus_read(32'h8000_0010, d);
        check_eq("unmapped_read", d, 32'h0);
        bus_read(32'h0000_0000, d);
        check_eq("alias_read", d, 32'h0);
        // Near-miss addresses must not start a transmission.
        bus_write(32'h0000_0008, 32'h0000_0055);
        bus_write(32'h8000_0018, 32'h0000_0055);
        step();
        check_eq("unmapped_write_line", {31'b0, serial_tx}, 32'h1);
        rd_txc("unmapped_write_ready", 1'b1);

        // TX frame with a dropped store during the frame.
        tx_frame_check(8'hA5, 1'b1);

        // Single RX frame.
        rx_frame(8'h3C);
        rd_rxc("rx1_ctrl");
        rd_rxd("rx1_data");
        rd_rxc("rx1_ctrl_clr");

        // Overrun.
        rx_frame(8'h11);
        rx_frame(8'h22);
        rd_rxc("ovr_ctrl");
        rd_rxd("ovr_data");
        rd_rxc("ovr_ctrl_clr");

        // Glitch, then framing error, then a good frame.
        serial_rx = 1'b0;
        repeat (100) step();
        serial_rx = 1'b1;
        repeat (2 * CPB) step();
        rd_rxc("glitch_ctrl");
        rx_drive(8'h5A, 300);
        repeat (CPB) step();
        rd_rxc("framing_ctrl");
        rx_frame(8'h55);
        rd_rxc("after_framing_ctrl");
        rd_rxd("after_framing_data");

        // Mid-frame reset: TX sending 0x00 and RX receiving 0x00 together.
        addr      = A_TXD;
        wdata     = 32'h0;
        we        = 1'b1;
        serial_rx = 1'b0;
        step();
        we   = 1'b0;
        addr = '0;
        repeat (1999) step();
        check_eq("tx_before_rst", {31'b0, serial_tx}, 32'h0);
        rst       = 1'b1;
        serial_rx = 1'b1;
        step();
        check_eq("tx_after_rst", {31'b0, serial_tx}, 32'h1);
        repeat (2) step();
        rst = 1'b0;
        model_clear();
        m_byte = 8'h00;
        repeat (2 * CPB) step();
        rd_rxc("rst_mid_rx_ctrl");
        rd_txc("rst_mid_tx_ready", 1'b1);
        tx_frame_check(8'h7E, 1'b0);
        rx_frame(8'h7E);
        rd_rxc("rt_ctrl");
        rd_rxd("rt_data");

        // Randomized RX traffic with random polling against the model.
        for (int i = 0; i < 4; i++) begin
            b = 8'($urandom_range(0, 255));
            rx_frame(b);
            if ($urandom_range(0, 1) == 1) rd_rxc($sformatf("rand_rx%0d_ctrl", i));
            if ($urandom_range(0, 1) == 1) rd_rxd($sformatf("rand_rx%0d_data", i));
        end
        rd_rxc("rand_rx_ctrl_end");
        rd_rxd("rand_rx_data_end");
        rd_rxc("rand_rx_ctrl_clr");

        // Randomized TX bytes.
        for (int i = 0; i < 2; i++) begin
            b = 8'($urandom_range(0, 255));
            tx_frame_check(b, $urandom_range(0, 1) == 1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
